// File: rtl/pipe_pkg.sv
// Shared pipeline types: bus widths and payload layouts, div_op bit positions,
// and the divider FSM state type.
package pipe_pkg;

    localparam int unsigned ID_EXE_BUS_W  = 184;
    localparam int unsigned EXE_MEM_BUS_W = 103;
    localparam int unsigned WR_BUS_W      = 38;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_CYCLES) + 1;

    // One-hot div_op bit positions
    localparam int unsigned DIV_W_BIT  = 3;
    localparam int unsigned MOD_W_BIT  = 2;
    localparam int unsigned DIV_WU_BIT = 1;
    localparam int unsigned MOD_WU_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [3:0]  div_op;
        logic [11:0] alu_op;
        logic        gr_we;
        logic        mem_we;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
    } id_exe_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
    } exe_mem_bus_t;

    typedef struct packed {
        logic        exe_en_bypass;
        logic [4:0]  dest;
        logic [31:0] result;
    } exe_wr_bus_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed & v[31]) ? 32'(~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU; alu_op is one-hot:
// add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (bits 0..11).
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [4:0]  shamt;

    always_comb begin
        add_res = alu_src1 + alu_src2;
        sub_res = alu_src1 - alu_src2;
        shamt   = alu_src2[4:0];
        alu_result = ({32{alu_op[0]}}  & add_res)
                   | ({32{alu_op[1]}}  & sub_res)
                   | ({32{alu_op[2]}}  & {31'd0, $signed(alu_src1) < $signed(alu_src2)})
                   | ({32{alu_op[3]}}  & {31'd0, alu_src1 < alu_src2})
                   | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                   | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[8]}}  & (alu_src1 << shamt))
                   | ({32{alu_op[9]}}  & (alu_src1 >> shamt))
                   | ({32{alu_op[10]}} & 32'($signed(alu_src1) >>> shamt))
                   | ({32{alu_op[11]}} & alu_src2);
    end
endmodule

// File: rtl/exe_div.sv
// Iterative restoring 32-bit divider: one quotient bit per cycle on operand
// magnitudes, sign fix and divide-by-zero handling applied on the held result.
module exe_div
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    div_state_e            state_q, state_d;
    logic [DIV_CNT_W-1:0]  count_q, count_d;
    logic [31:0]           quo_q, quo_d;
    logic [31:0]           rem_q, rem_d;
    logic [31:0]           dvs_q, dvs_d;
    logic [31:0]           dvd_q, dvd_d;
    logic                  zero_q, zero_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [32:0]           rem_shift;
    logic [33:0]           diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        dvs_q     <= dvs_d;
        dvd_q     <= dvd_d;
        zero_q    <= zero_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        zero_d    = zero_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_shift = {rem_q, quo_q[31]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = BUSY;
                    count_d   = '0;
                    quo_d     = abs32(dividend, is_signed);
                    rem_d     = '0;
                    dvs_d     = abs32(divisor, is_signed);
                    dvd_d     = dividend;
                    zero_d    = (divisor == 32'd0);
                    neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
                    neg_rem_d = is_signed & dividend[31];
                end
            end
            BUSY: begin
                count_d = count_q + DIV_CNT_W'(1);
                // Restore when the trial subtraction goes negative
                if (diff[33]) begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end else begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end
                if (count_q == DIV_CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done      = (state_q == DONE);
        quotient  = zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? 32'(~quo_q + 32'd1) : quo_q);
        remainder = zero_q ? dvd_q         : (neg_rem_q ? 32'(~rem_q + 32'd1) : rem_q);
    end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, data-SRAM request, EXE->MEM and forwarding buses.
// Divider for div/mod instructions is present only when EXE_DIV_EN is defined.
module exe_stage
    import pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_exe_valid,
    output logic                     exe_allowin,
    output logic                     exe_mem_valid,
    input  logic                     mem_allowin,
    input  logic [ID_EXE_BUS_W-1:0]  id_exe_bus,
    output logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
    output logic [WR_BUS_W-1:0]      exe_wr_bus,
    output logic                     exe_fwd_stall,
    output logic                     data_sram_en,
    output logic [3:0]               data_sram_we,
    output logic [31:0]              data_sram_addr,
    output logic [31:0]              data_sram_wdata
);
    logic         exe_valid_q, exe_valid_d;
    id_exe_bus_t  bus_q, bus_d;
    logic [31:0]  alu_result;
    logic [31:0]  result;
    logic         exe_ready_go;
    logic         exe_en_bypass;
    exe_mem_bus_t mem_bus;
    exe_wr_bus_t  wr_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid_q <= 1'b0;
        end else begin
            exe_valid_q <= exe_valid_d;
        end
        bus_q <= bus_d;
    end

    alu u_alu (
        .alu_op     (bus_q.alu_op),
        .alu_src1   (bus_q.src1),
        .alu_src2   (bus_q.src2),
        .alu_result (alu_result)
    );

`ifdef EXE_DIV_EN
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        is_div;
    logic        is_signed;
    logic        want_rem;

    always_comb begin
        is_div    = (bus_q.div_op != 4'd0);
        is_signed = ~(bus_q.div_op[DIV_WU_BIT] | bus_q.div_op[MOD_WU_BIT]);
        want_rem  = bus_q.div_op[MOD_W_BIT] | bus_q.div_op[MOD_WU_BIT];
    end

    exe_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (exe_valid_q & is_div),
        .ack       (exe_mem_valid & mem_allowin),
        .is_signed (is_signed),
        .dividend  (bus_q.src1),
        .divisor   (bus_q.src2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        exe_ready_go = ~is_div | div_done;
        result       = alu_result;
        if (is_div) begin
            result = want_rem ? div_rem : div_quo;
        end
    end
`else
    logic unused_div_op;

    always_comb begin
        unused_div_op = ^bus_q.div_op;
        exe_ready_go  = 1'b1;
        result        = alu_result;
    end
`endif

    // Handshake and input capture
    always_comb begin
        exe_mem_valid = exe_valid_q & exe_ready_go;
        exe_allowin   = ~exe_valid_q | (exe_ready_go & mem_allowin);
        exe_valid_d   = exe_valid_q;
        bus_d         = bus_q;
        if (exe_allowin) begin
            exe_valid_d = id_exe_valid;
        end
        if (id_exe_valid & exe_allowin) begin
            bus_d = id_exe_bus_t'(id_exe_bus);
        end
    end

    always_comb begin
        data_sram_en    = exe_valid_q & (bus_q.mem_we | bus_q.res_from_mem) & mem_allowin;
        data_sram_we    = {4{exe_valid_q & bus_q.mem_we & mem_allowin}};
        data_sram_addr  = alu_result;
        data_sram_wdata = bus_q.rkd_value;

        exe_en_bypass = exe_valid_q & bus_q.gr_we & (bus_q.dest != 5'd0);
        // Loads and unfinished divides have no forwardable value yet
        exe_fwd_stall = exe_en_bypass & (bus_q.res_from_mem | ~exe_ready_go);

        mem_bus.gr_we        = bus_q.gr_we;
        mem_bus.res_from_mem = bus_q.res_from_mem;
        mem_bus.dest         = bus_q.dest;
        mem_bus.pc           = bus_q.pc;
        mem_bus.inst         = bus_q.inst;
        mem_bus.result       = result;
        exe_mem_bus          = mem_bus;

        wr_bus.exe_en_bypass = exe_en_bypass;
        wr_bus.dest          = bus_q.dest;
        wr_bus.result        = result;
        exe_wr_bus           = wr_bus;
    end
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an instruction-level model.
`timescale 1ns/1ps
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         id_exe_valid;
    logic         exe_allowin;
    logic         exe_mem_valid;
    logic         mem_allowin;
    logic [183:0] id_exe_bus;
    logic [102:0] exe_mem_bus;
    logic [37:0]  exe_wr_bus;
    logic         exe_fwd_stall;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    localparam logic [11:0] OP_ADD = 12'h001;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_exe_valid    (id_exe_valid),
        .exe_allowin     (exe_allowin),
        .exe_mem_valid   (exe_mem_valid),
        .mem_allowin     (mem_allowin),
        .id_exe_bus      (id_exe_bus),
        .exe_mem_bus     (exe_mem_bus),
        .exe_wr_bus      (exe_wr_bus),
        .exe_fwd_stall   (exe_fwd_stall),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference semantics ----------------
    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        if (op[0])  r = a + b;
        if (op[1])  r = a - b;
        if (op[2])  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[3])  r = (a < b) ? 32'd1 : 32'd0;
        if (op[4])  r = a & b;
        if (op[5])  r = ~(a | b);
        if (op[6])  r = a | b;
        if (op[7])  r = a ^ b;
        if (op[8])  r = a << b[4:0];
        if (op[9])  r = a >> b[4:0];
        if (op[10]) r = 32'($signed(a) >>> b[4:0]);
        if (op[11]) r = b;
        return r;
    endfunction

    function automatic logic [31:0] div_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [31:0] uq, ur;
        bit          want_rem;
        want_rem = op[2] | op[0];
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        if (op[3] | op[2]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            uq = q[31:0];
            ur = r[31:0];
        end else begin
            uq = a / b;
            ur = a % b;
        end
        return want_rem ? ur : uq;
    endfunction

    function automatic logic [31:0] res_ref(input logic [183:0] bus);
        logic [3:0]  dop;
        logic [11:0] aop;
        logic [31:0] s1, s2;
        dop = bus[183:180];
        aop = bus[179:168];
        s1  = bus[95:64];
        s2  = bus[63:32];
`ifdef EXE_DIV_EN
        if (dop != 4'd0) return div_ref(dop, s1, s2);
`endif
        return alu_ref(aop, s1, s2);
    endfunction

    // ---------------- instruction-level model ----------------
    logic         m_valid = 1'b0;
    logic [183:0] m_bus   = '0;
    int           m_age   = 0;

    function automatic bit m_ready();
`ifdef EXE_DIV_EN
        return (m_bus[183:180] == 4'd0) || (m_age >= 33);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
        end else if (!m_valid || (m_ready() && mem_allowin)) begin
            m_valid = id_exe_valid;
            if (id_exe_valid) begin
                m_bus = id_exe_bus;
                m_age = 0;
            end
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        bit          rdy, byp, gw, mw, rfm, sen;
        logic [4:0]  dst;
        logic [31:0] res;
        if (checking) begin
            rdy = m_ready();
            gw  = m_bus[167];
            mw  = m_bus[166];
            rfm = m_bus[165];
            dst = m_bus[164:160];
            res = res_ref(m_bus);
            byp = m_valid && gw && (dst != 5'd0);
            sen = m_valid && (mw || rfm) && mem_allowin;
            chk("mem_valid", exe_mem_valid, m_valid && rdy);
            chk("allowin", exe_allowin, !m_valid || (rdy && mem_allowin));
            chk("bypass_en", exe_wr_bus[37], byp);
            chk("fwd_stall", exe_fwd_stall, byp && (rfm || !rdy));
            chk("sram_en", data_sram_en, sen);
            chk("sram_we", data_sram_we, {4{m_valid && mw && mem_allowin}});
            if (m_valid && rdy)
                chk("mem_bus", exe_mem_bus, {gw, rfm, dst, m_bus[159:128], m_bus[127:96], res});
            if (byp && rdy)
                chk("wr_bus", exe_wr_bus, {1'b1, dst, res});
            if (sen) begin
                chk("sram_addr", data_sram_addr, alu_ref(m_bus[179:168], m_bus[95:64], m_bus[63:32]));
                chk("sram_wdata", data_sram_wdata, m_bus[31:0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [183:0] mk(input logic [3:0] dop, input logic [11:0] aop, input logic gw,
                                        input logic mw, input logic rfm, input logic [4:0] dst,
                                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd);
        logic [31:0] pc, inst;
        pc   = 32'h1c00_0000 + ($urandom % 1024) * 4;
        inst = $urandom;
        return {dop, aop, gw, mw, rfm, dst, pc, inst, s1, s2, rkd};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom % 20);
            4:       return 32'(0 - ($urandom % 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        id_exe_valid = 1'b1;
        id_exe_bus   = mk(op, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd4, a, b, 32'd0);
        cyc();
        id_exe_valid = 1'b0;
        n = 0;
        settle();
        while (!exe_mem_valid && n < 100) begin
            chk({name, " stall"}, exe_fwd_stall, 1'b1);
            cyc();
            n++;
            settle();
        end
        chk({name, " latency"}, n, 33);
        chk({name, " result"}, exe_mem_bus[31:0], exp);
        cyc();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int pulses;
        reset        = 1'b1;
        id_exe_valid = 1'b0;
        mem_allowin  = 1'b1;
        id_exe_bus   = '0;
        cyc();
        cyc();
        reset    = 1'b0;
        checking = 1'b1;
        settle();
        chk("reset allowin", exe_allowin, 1'b1);
        chk("reset mem_valid", exe_mem_valid, 1'b0);
        chk("reset sram_en", data_sram_en, 1'b0);
        chk("reset fwd_stall", exe_fwd_stall, 1'b0);

        // add, st.w, ld.w back to back
        cyc();
        id_exe_valid = 1'b1;
        id_exe_bus   = mk(4'd0, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd1, 32'd5, 32'd7, 32'd0);
        cyc();
        id_exe_bus   = mk(4'd0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1000, 32'd8, 32'hDEAD_BEEF);
        settle();
        chk("add valid", exe_mem_valid, 1'b1);
        chk("add result", exe_mem_bus[31:0], 32'd12);
        cyc();
        id_exe_bus   = mk(4'd0, OP_ADD, 1'b1, 1'b0, 1'b1, 5'd2, 32'h1000, 32'd8, 32'd0);
        settle();
        chk("st we", data_sram_we, 4'hF);
        chk("st addr", data_sram_addr, 32'h1008);
        chk("st wdata", data_sram_wdata, 32'hDEAD_BEEF);
        cyc();
        id_exe_valid = 1'b0;
        settle();
        chk("ld fwd_stall", exe_fwd_stall, 1'b1);
        chk("ld sram_en", data_sram_en, 1'b1);
        chk("ld sram_we", data_sram_we, 4'h0);
        cyc();

        // store held by MEM backpressure
        id_exe_valid = 1'b1;
        id_exe_bus   = mk(4'd0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'h4, 32'h1234_5678);
        cyc();
        id_exe_valid = 1'b0;
        mem_allowin  = 1'b0;
        pulses = 0;
        repeat (3) begin
            settle();
            chk("bp allowin", exe_allowin, 1'b0);
            chk("bp sram_en", data_sram_en, 1'b0);
            if (data_sram_we == 4'hF) pulses++;
            cyc();
        end
        mem_allowin = 1'b1;
        settle();
        chk("bp release addr", data_sram_addr, 32'h24);
        if (data_sram_we == 4'hF) pulses++;
        cyc();
        settle();
        if (data_sram_we == 4'hF) pulses++;
        chk("bp write pulses", pulses, 1);
        cyc();

`ifdef EXE_DIV_EN
        run_div("div.w -7/2", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod.w -7/2", 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div.wu x/0", 4'b0010, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        run_div("mod.wu x/0", 4'b0001, 32'h8000_0000, 32'd0, 32'h8000_0000);
        run_div("div.w min/-1", 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // reset in the middle of a division (BUSY count 10)
        id_exe_valid = 1'b1;
        id_exe_bus   = mk(4'b1000, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd6, 32'd1000, 32'd3, 32'd0);
        cyc();
        id_exe_valid = 1'b0;
        repeat (11) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("midreset allowin", exe_allowin, 1'b1);
        chk("midreset mem_valid", exe_mem_valid, 1'b0);
        chk("midreset fwd_stall", exe_fwd_stall, 1'b0);
        cyc();
        run_div("div.wu after reset", 4'b0010, 32'd1000, 32'd3, 32'd333);

        // back-to-back divides
        begin
            int          k, t0, t1, cnt;
            logic [31:0] r0, r1;
            bit          acc;
            k = 0; t0 = 0; t1 = 0; cnt = 0; r0 = '0; r1 = '0;
            id_exe_valid = 1'b1;
            id_exe_bus   = mk(4'b0010, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd7, 32'd100, 32'd7, 32'd0);
            cyc();
            id_exe_bus   = mk(4'b0001, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd8, 32'd100, 32'd7, 32'd0);
            while (k < 2 && cnt < 200) begin
                settle();
                if (exe_mem_valid) begin
                    if (k == 0) begin t0 = cnt; r0 = exe_mem_bus[31:0]; end
                    else begin t1 = cnt; r1 = exe_mem_bus[31:0]; end
                    k++;
                end
                acc = id_exe_valid && exe_allowin;
                cyc();
                cnt++;
                if (acc) id_exe_valid = 1'b0;
            end
            chk("b2b count", k, 2);
            chk("b2b div.wu", r0, 32'd14);
            chk("b2b mod.wu", r1, 32'd2);
            chk("b2b spacing", t1 - t0, 34);
        end
`else
        id_exe_valid = 1'b1;
        id_exe_bus   = mk(4'b1000, OP_ADD, 1'b1, 1'b0, 1'b0, 5'd3, 32'd3, 32'd4, 32'd0);
        cyc();
        id_exe_valid = 1'b0;
        settle();
        chk("nodiv valid", exe_mem_valid, 1'b1);
        chk("nodiv result", exe_mem_bus[31:0], 32'd7);
        chk("nodiv fwd_stall", exe_fwd_stall, 1'b0);
        cyc();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int kind;
            reset        = ($urandom_range(0, 399) == 0);
            mem_allowin  = ($urandom_range(0, 3) != 0);
            id_exe_valid = ($urandom_range(0, 9) < 7);
            kind = $urandom_range(0, 9);
            if (kind <= 5)
                id_exe_bus = mk(4'd0, 12'(1) << $urandom_range(0, 11), 1'($urandom), 1'b0, 1'b0,
                                5'($urandom), pick(), pick(), $urandom);
            else if (kind <= 7)
                id_exe_bus = mk(4'd0, OP_ADD, 1'b1, 1'b0, 1'b1, 5'($urandom), $urandom, pick(), $urandom);
            else if (kind == 8)
                id_exe_bus = mk(4'd0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'($urandom), $urandom, pick(), $urandom);
            else
                id_exe_bus = mk(4'b0001 << $urandom_range(0, 3), 12'(1) << $urandom_range(0, 11), 1'b1,
                                1'b0, 1'b0, 5'($urandom), pick(), pick(), $urandom);
            cyc();
        end
        reset        = 1'b0;
        id_exe_valid = 1'b0;
        mem_allowin  = 1'b1;
        repeat (40) cyc();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Runs the existing `alu` on operands decoded by ID.
- Issues the data-SRAM request so MEM can consume `data_sram_rdata` the next cycle.
- Runs an iterative 32-bit divider for div/mod instructions, stalling with the valid/allowin handshake.
- Produces the 103-bit `exe_mem_bus` and an EXE forwarding bus for ID.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles; fixed to data width, not user-tunable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_exe_valid  in  1  ID holds a valid instruction for EXE
- exe_allowin  out  1  EXE can accept from ID this cycle
- exe_mem_valid  out  1  EXE presents a completed instruction to MEM
- mem_allowin  in  1  MEM can accept this cycle
- id_exe_bus  in  184  {div_op[3:0], alu_op[11:0], gr_we, mem_we, res_from_mem, dest[4:0], pc[31:0], inst[31:0], src1[31:0], src2[31:0], rkd_value[31:0]}
- exe_mem_bus  out  103  {gr_we, res_from_mem, dest[4:0], pc[31:0], inst[31:0], result[31:0]}
- exe_wr_bus  out  38  {exe_en_bypass, dest[4:0], result[31:0]}
- exe_fwd_stall  out  1  EXE writes a reg whose value is not yet forwardable
- data_sram_en  out  1  SRAM request enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  = ALU result
- data_sram_wdata  out  32  = rkd_value

Behaviour:
- Handshake:
  - exe_ready_go = 1 for non-div instructions; = (div_state==DONE) for div_op!=0.
  - exe_mem_valid = exe_valid & exe_ready_go.
  - exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin).
- exe_valid:
  - Cleared on reset.
  - Loads id_exe_valid when exe_allowin.
  - Bus register captures id_exe_bus when id_exe_valid & exe_allowin; holds otherwise.
- div_op encoding (one-hot, bits 3..0): div.w, mod.w, div.wu, mod.wu. div_op==0 means ALU instruction. More than one bit set is illegal; behaviour undefined.
- result = div_op ? (quotient or remainder per div_op) : alu_result.
- SRAM request:
  - data_sram_en = exe_valid & (mem_we | res_from_mem) & mem_allowin.
  - data_sram_we = {4{exe_valid & mem_we & mem_allowin}}.
  - Issued exactly once, in the cycle the instruction moves to MEM.
- Forwarding:
  - exe_en_bypass = exe_valid & gr_we & (dest!=0).
  - exe_fwd_stall = exe_en_bypass & (res_from_mem | ~exe_ready_go).
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when exe_valid & div_op!=0. Latch |dividend|, |divisor| (signed ops) or raw values (unsigned); count=0.
  - BUSY: one restoring step per cycle, count++. After DIV_CYCLES steps -> DONE.
  - DONE -> IDLE when exe_mem_valid & mem_allowin. Result is held stable while in DONE.
  - Minimum EXE occupancy for a div is 34 cycles: 1 IDLE + 32 BUSY + 1 DONE.
- Sign fix (signed ops only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (32-bit wrap).
- Divisor zero (all ops, no sign fix): quotient = 0xFFFFFFFF, remainder = dividend.
- Reset: synchronous, active-high. Forces exe_valid=0 and div_state=IDLE, including mid-division. All outputs then derive from exe_valid=0: exe_mem_valid=0, exe_allowin=1, data_sram_en=0, data_sram_we=0, exe_en_bypass=0, exe_fwd_stall=0.
- Back-to-back divs: the next div may enter on the same edge DONE->IDLE. It starts BUSY one cycle later.

Optional Feature:
- Macro: EXE_DIV_EN.
- Defined: divider sub-module instantiated and the behaviour above applies.
- Undefined:
  - No divider logic.
  - div_op ignored; result = alu_result.
  - exe_ready_go = 1 always.
  - exe_fwd_stall = exe_en_bypass & res_from_mem.

Decomposition:
- Shared package `pipe_pkg`:
  - Bus width constants: ID_EXE_BUS_W=184, EXE_MEM_BUS_W=103, WR_BUS_W=38.
  - DIV_OP bit indices.
  - div FSM state enum.
- One sub-module: `exe_div`.
  - Inputs: start, signed, op values.
  - Outputs: done, quotient, remainder.
  - Contains the FSM, counter and sign fix.
- The ALU reuses the existing `alu` module.

Test Plan:
- Load/store: add, st.w, then ld.w to same addr with mem_allowin=1.
  - Each instruction spends 1 cycle in EXE.
  - st.w cycle: data_sram_we=4'hF, addr=ALU result, wdata=rkd_value.
  - ld.w cycle: exe_fwd_stall=1.
- MEM backpressure: mem_allowin=0 for 3 cycles with st.w in EXE.
  - exe_allowin=0 and data_sram_en=0 throughout.
  - Exactly one write pulse when mem_allowin rises.
- div.w -7/2: exe_mem_valid rises 33 cycles after entry.
  - result=0xFFFFFFFD; mod.w gives 0xFFFFFFFF.
  - exe_fwd_stall=1 until DONE.
- Edge divides: div.wu 0x80000000/0 gives 0xFFFFFFFF; mod.wu gives 0x80000000; div.w 0x80000000/0xFFFFFFFF gives 0x80000000.
- Reset asserted at BUSY count 10:
  - Next cycle exe_valid=0, state IDLE, exe_allowin=1.
  - A subsequent div completes normally.
- Back-to-back div.wu 100/7 and mod.wu 100/7:
  - Results 14 then 2.
  - Second exe_mem_valid is 34 cycles after the first.
